// File: rtl/acc_pkg.sv
// acc_pkg: shared types for the accelerator FPU sharing logic.
// Rev 1.0
`default_nettype none

package acc_pkg;

  localparam int NUM_SRC = 2;

  typedef enum logic [0:0] {
    SRC_CPU = 1'b0,
    SRC_PIV = 1'b1
  } acc_src_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  op;
    logic [3:0]  tag;
  } fpu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  tag;
    logic [4:0]  status;
  } fpu_resp_t;

endpackage

`default_nettype wire

// File: rtl/acc_src_fifo.sv
// acc_src_fifo: in-order FIFO of issuing sources, depth DEPTH (power of two).
// Rev 1.0
`default_nettype none

module acc_src_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  acc_src_e         wdata,
  input  logic             pop,
  output acc_src_e         rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  acc_src_e         mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Pointers wrap naturally; full/empty come from count in the parent.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

`default_nettype wire

// File: rtl/acc_fpu_arb.sv
// acc_fpu_arb: round-robin sharing of one FPU between CPU and pivot sequencer,
// with in-order result routing. Rev 1.0
`default_nettype none

module acc_fpu_arb
  import acc_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_SRC-1:0]       src_req_valid_i,
  output logic [NUM_SRC-1:0]       src_req_ready_o,
  input  fpu_req_t [NUM_SRC-1:0]   src_req_i,
  output logic                     fpu_in_valid_o,
  input  logic                     fpu_in_ready_i,
  output fpu_req_t                 fpu_req_o,
  input  logic                     fpu_out_valid_i,
  output logic                     fpu_out_ready_o,
  input  fpu_resp_t                fpu_resp_i,
  output logic [NUM_SRC-1:0]       src_resp_valid_o,
  input  logic [NUM_SRC-1:0]       src_resp_ready_i,
  output fpu_resp_t                src_resp_o,
  output logic [CNT_W-1:0]         inflight_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  acc_src_e         rr_prio;
  acc_src_e         lock_src;
  acc_src_e         grant;
  acc_src_e         head;
  logic [CNT_W-1:0] count;
  logic             run;
  logic             full;
  logic             empty;
  logic             req_valid;
  logic             fire;
  logic             pop;

  // rst_ni is active-high; every combinational output is held at 0 during reset.
  assign run   = ~rst_ni;
  assign full  = (count == CNT_W'(MAX_INFLIGHT));
  assign empty = (count == '0);

  always_comb begin
    grant = rr_prio;
    if (state == ST_LOCKED)            grant = lock_src;
    else if (src_req_valid_i == 2'b01) grant = SRC_CPU;
    else if (src_req_valid_i == 2'b10) grant = SRC_PIV;
  end

  assign req_valid      = run && !full && src_req_valid_i[grant];
  assign fire           = req_valid && fpu_in_ready_i;
  assign fpu_in_valid_o = req_valid;
  assign fpu_req_o      = run ? src_req_i[grant] : '0;

  always_comb begin
    src_req_ready_o = '0;
    if (fire) src_req_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state    <= ST_IDLE;
      lock_src <= SRC_CPU;
      rr_prio  <= SRC_CPU;
      err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && !fpu_in_ready_i) begin
            state    <= ST_LOCKED;
            lock_src <= grant;
          end
        end
        ST_LOCKED: if (fire) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      if (fire) rr_prio <= (grant == SRC_CPU) ? SRC_PIV : SRC_CPU;
      if (fpu_out_valid_i && empty) err_o <= 1'b1;
    end
  end

  // Results with no recorded issuer are accepted and dropped.
  always_comb begin
    src_resp_valid_o = '0;
    fpu_out_ready_o  = 1'b0;
    if (run) begin
      if (empty) begin
        fpu_out_ready_o = fpu_out_valid_i;
      end else begin
        src_resp_valid_o[head] = fpu_out_valid_i;
        fpu_out_ready_o        = src_resp_ready_i[head];
      end
    end
  end

  assign pop        = fpu_out_valid_i && fpu_out_ready_o && !empty;
  assign src_resp_o = run ? fpu_resp_i : '0;
  assign inflight_o = count;
  assign busy_o     = run && ((count != '0) || (|src_req_valid_i));

  acc_src_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .CNT_W (CNT_W)
  ) u_src_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fire),
    .wdata  (grant),
    .pop    (pop),
    .rdata  (head),
    .count  (count)
  );

endmodule

`default_nettype wire

// File: doc/acc_fpu_arb.md
Name: acc_fpu_arb

Overview:
- Shares the single fpnew FPU instance between two requesters: the CPU vanilla-FPU path (source 0) and the pivot sequencer (source 1).
- Round-robin arbitrates issue requests.
- Records the source of every issued operation in an in-order source FIFO, and uses it to route each FPU result back to the source that issued it.
- Sits between the accelerator control logic and the FPU; owns the FPU's input and output handshakes.

Parameters:
- MAX_INFLIGHT, 4, maximum operations issued to the FPU and not yet returned; source FIFO depth; power of two, ≥2.
- CNT_W, $clog2(MAX_INFLIGHT)+1, width of the in-flight counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-high
- src_req_valid_i  in  2  per-source request valid; bit0 = CPU, bit1 = pivot
- src_req_ready_o  out  2  per-source request accepted this cycle
- src_req_i  in  2 x fpu_req_t  per-source FPU request
- fpu_in_valid_o  out  1  FPU input valid
- fpu_in_ready_i  in  1  FPU input ready
- fpu_req_o  out  fpu_req_t  muxed request to FPU
- fpu_out_valid_i  in  1  FPU result valid
- fpu_out_ready_o  out  1  FPU result ready
- fpu_resp_i  in  fpu_resp_t  FPU result (result, tag, status)
- src_resp_valid_o  out  2  per-source result valid
- src_resp_ready_i  in  2  per-source result ready
- src_resp_o  out  fpu_resp_t  result; broadcast to both sources, qualified by src_resp_valid_o
- inflight_o  out  CNT_W  operations outstanding in the FPU
- busy_o  out  1  inflight_o != 0 or any src_req_valid_i
- err_o  out  1  sticky: FPU produced a result while the source FIFO was empty

Behaviour:
- Reset (async, rst_ni=1):
  - all outputs 0; src_req_ready_o = 0; fpu_out_ready_o = 0.
  - rr pointer = source 0 has priority; FIFO empty; lock cleared; err_o cleared.
  - Asserting reset mid-operation discards in-flight bookkeeping; results returned after reset count as unexpected (see err_o).
- Issue FSM, states IDLE and LOCKED:
  - IDLE: if FIFO is not full and any valid, grant = round-robin winner; fpu_in_valid_o = 1 and fpu_req_o = src_req_i[grant] combinationally.
  - If fpu_in_ready_i = 1 that cycle: fire, src_req_ready_o[grant] = 1, push grant into the FIFO, rr pointer moves to ~grant, stay in IDLE.
  - If fpu_in_ready_i = 0: latch grant and go to LOCKED.
  - LOCKED: grant is held (no re-arbitration, so fpu_req_o is stable while valid). Return to IDLE on fire.
  - A source must hold valid and its payload until ready; deasserting valid in LOCKED is a protocol violation (not checked).
- Round-robin:
  - Both sources valid: the source ≠ last-fired wins.
  - Single valid source wins regardless of the pointer.
  - The pointer updates only on fire.
- Full: when FIFO count = MAX_INFLIGHT, fpu_in_valid_o = 0 and all ready = 0.
  - Exception: a result pop in the same cycle does not free a slot for that cycle's issue (no bypass; avoids a comb path from fpu_out_valid_i to fpu_in_valid_o).
- Return path:
  - The FPU returns results in issue order (FPU configured with uniform latency); decided.
  - head = FIFO head source.
  - src_resp_valid_o[head] = fpu_out_valid_i when FIFO is not empty; src_resp_o = fpu_resp_i.
  - fpu_out_ready_o = src_resp_ready_i[head].
  - Pop on fpu_out_valid_i && fpu_out_ready_o.
  - Empty FIFO and fpu_out_valid_i = 1: fpu_out_ready_o = 1 (drop the result), set err_o, no resp valid.
- Counter:
  - inflight_o = FIFO count, registered.
  - Push and pop in the same cycle leave the count unchanged.
  - FIFO pointers are $clog2(MAX_INFLIGHT) bits and wrap naturally; full/empty are taken from the count.
- Latency: zero-cycle pass-through on both paths; the block adds no pipeline stage.

Decomposition:
- acc_pkg additions:
  - typedef acc_src_e {SRC_CPU=0, SRC_PIV=1}
  - localparam NUM_SRC = 2
- Sub-module acc_src_fifo:
  - parameterised sync FIFO of acc_src_e, depth MAX_INFLIGHT.
  - Ports: push/pop/data/count.
  - Reset shares the same async active-high rst_ni.

Test Plan:
- Single CPU op, fpu_in_ready_i=1, result 5 cycles later with tag 3 → src_req_ready_o=01 in cycle 0; inflight_o 1 then 0; src_resp_valid_o=01 with tag 3.
- Both sources valid for 4 cycles, ready=1, FPU latency 8 → grants CPU, PIV, CPU, PIV; results return valid 01,10,01,10.
- CPU valid with fpu_in_ready_i low for 3 cycles; PIV raises valid in cycle 1 → fpu_req_o stays CPU's payload all 3 cycles; PIV is granted the cycle after CPU fires.
- Issue 4 ops with no returns → inflight_o=4, fpu_in_valid_o=0 while sources keep valid; one return → issue resumes the next cycle.
- Result for PIV with src_resp_ready_i[1]=0 for 2 cycles → fpu_out_ready_o=0 for 2 cycles; pop and inflight decrement only when ready rises.
- fpu_out_valid_i with FIFO empty, then reset asserted mid-traffic → err_o=1 and fpu_out_ready_o=1; after reset all outputs are 0 and err_o is cleared.
